// File: rtl/keypad_mmio_pkg.sv
// Shared definitions for the keypad peripheral: function codes, address
// field offsets and register bit positions.
package keypad_mmio_pkg;

  typedef enum logic [3:0] {
    FUNC_LED    = 4'd0,
    FUNC_GLYPH  = 4'd1,
    FUNC_STATUS = 4'd2,
    FUNC_GLOBAL = 4'd3,
    FUNC_LOG    = 4'd4
  } func_e;

  // Address fields: func = addr[11:8], key = addr[3:0]
  localparam int FUNC_LSB = 8;
  localparam int KEY_LSB  = 0;

  // Key status register
  localparam int ST_LEVEL_BIT = 0;
  localparam int ST_PRESS_BIT = 1;

  // Global register
  localparam int GL_VALID_BIT = 0;
  localparam int GL_OVR_BIT   = 1;
  localparam int GL_LOVF_BIT  = 2;
  localparam int GL_COUNT_LSB = 8;

  // Log pop word
  localparam int LOG_VALID_BIT = 15;

  // Number of set bits in a key vector (at most 16 keys)
  function automatic logic [4:0] count_ones(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/keypad_mmio_if.sv
// Bus and glyph-handshake bundle for keypad_mmio. The master side is the
// CPU bus together with the OLED driver; the slave side is the peripheral.
interface keypad_mmio_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic                  en;
  logic [DATA_WIDTH-1:0] q;
  logic                  glyph_valid;
  logic [3:0]            glyph_key;
  logic [DATA_WIDTH-1:0] glyph_data;
  logic                  glyph_ready;

  modport master (
    output data, addr, we, en, glyph_ready,
    input  q, glyph_valid, glyph_key, glyph_data
  );

  modport slave (
    input  data, addr, we, en, glyph_ready,
    output q, glyph_valid, glyph_key, glyph_data
  );
endinterface

// File: rtl/keypad_mmio_debounce.sv
// One key input path: 2-FF synchronizer, debounce counter and a one-cycle
// pulse on the rising edge of the debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then flip the level after DEBOUNCE_CYCLES consecutive differing samples
  // NOTE: every register here uses <= so all stages see the pre-edge values of their neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync0   <= raw;
      sync1   <= sync0;
      level_d <= level;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/keypad_mmio.sv
// Memory-mapped keypad: per-key LED, debounced status with sticky press
// flags, glyph ready/valid handshake and a registered read port.
// Optional macro KEYPAD_ORDER_LOG_EN adds an in-order press log (func 4).
module keypad_mmio
  import keypad_mmio_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_mmio_if.slave      bus,
  input  logic [N_KEYS-1:0] keys_in,
  output logic [N_KEYS-1:0] leds
);

  func_e                 func;
  logic [3:0]            key;
  logic                  key_ok;
  logic                  wr;
  logic                  rd;
  logic [N_KEYS-1:0]     level;
  logic [N_KEYS-1:0]     rise;
  logic [N_KEYS-1:0]     flags;
  logic                  ovr;
  logic                  lovf;
  logic                  sel_led;
  logic                  sel_level;
  logic                  sel_flag;
  logic [DATA_WIDTH-1:0] log_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_addr;

  assign func        = func_e'(bus.addr[FUNC_LSB +: 4]);
  assign key         = bus.addr[KEY_LSB +: 4];
  assign key_ok      = int'(key) < N_KEYS;
  assign wr          = bus.en && bus.we && key_ok;
  assign rd          = bus.en && !bus.we;
  assign unused_addr = ^bus.addr;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (keys_in[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // LED writes and press flags; a press wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      leds  <= '0;
      flags <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (wr && func == FUNC_LED && key == 4'(i)) leds[i] <= bus.data[0];
        if (rise[i])
          flags[i] <= 1'b1;
        else if (wr && func == FUNC_STATUS && key == 4'(i) && bus.data[ST_PRESS_BIT])
          flags[i] <= 1'b0;
      end
    end
  end

  // Glyph handshake; a write during the transfer cycle still counts as busy
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.glyph_valid <= 1'b0;
      bus.glyph_key   <= '0;
      bus.glyph_data  <= '0;
      ovr             <= 1'b0;
    end else begin
      if (bus.glyph_valid && bus.glyph_ready) bus.glyph_valid <= 1'b0;
      if (wr && func == FUNC_GLYPH) begin
        if (bus.glyph_valid) begin
          ovr <= 1'b1;
        end else begin
          bus.glyph_valid <= 1'b1;
          bus.glyph_key   <= key;
          bus.glyph_data  <= bus.data;
        end
      end else if (wr && func == FUNC_GLOBAL && bus.data[GL_OVR_BIT]) begin
        ovr <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_ORDER_LOG_EN
  localparam int PTR_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_KEYS - 1);

  logic [3:0]       log_mem [2**PTR_W];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       log_cnt;
  logic [3:0]       push_idx;
  logic             push_req;
  logic             push_multi;
  logic             push_ok;
  logic             pop;

  // Lowest pressed index this cycle
  // NOTE: default assignment first so the loop cannot leave push_idx unassigned (no latch).
  always_comb begin
    push_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) if (rise[i]) push_idx = 4'(i);
  end

  assign push_req   = |rise;
  assign push_multi = (rise & (rise - 1'b1)) != '0;
  assign pop        = rd && key_ok && func == FUNC_LOG && log_cnt != '0;
  assign push_ok    = push_req && (log_cnt != 5'(N_KEYS) || pop);

  // Log pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      log_cnt <= '0;
      lovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      log_cnt <= log_cnt + 5'(push_ok) - 5'(pop);
      if ((push_req && !push_ok) || push_multi)
        lovf <= 1'b1;
      else if (wr && func == FUNC_GLOBAL && bus.data[GL_LOVF_BIT])
        lovf <= 1'b0;
    end
  end

  // Log storage
  // NOTE: no reset on the storage array; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) log_mem[wr_ptr] <= push_idx;
  end

  always_comb begin
    log_word = '0;
    if (log_cnt != '0) begin
      log_word[LOG_VALID_BIT] = 1'b1;
      log_word[3:0]           = log_mem[rd_ptr];
    end
  end
`else
  assign lovf     = 1'b0;
  assign log_word = '0;
`endif

  // Pick the addressed key's LED, level and flag
  always_comb begin
    sel_led   = 1'b0;
    sel_level = 1'b0;
    sel_flag  = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (key == 4'(i)) begin
        sel_led   = leds[i];
        sel_level = level[i];
        sel_flag  = flags[i];
      end
    end
  end

  // Read data multiplexer; unmapped keys and functions read 0
  always_comb begin
    rd_data = '0;
    if (key_ok) begin
      case (func)
        FUNC_LED:    rd_data[0] = sel_led;
        FUNC_STATUS: begin
          rd_data[ST_LEVEL_BIT] = sel_level;
          rd_data[ST_PRESS_BIT] = sel_flag;
        end
        FUNC_GLOBAL: begin
          rd_data[GL_VALID_BIT]       = bus.glyph_valid;
          rd_data[GL_OVR_BIT]         = ovr;
          rd_data[GL_LOVF_BIT]        = lovf;
          rd_data[GL_COUNT_LSB +: 5]  = count_ones(16'(flags));
        end
        FUNC_LOG:    rd_data = log_word;
        default:     rd_data = '0;
      endcase
    end
  end

  // Registered read port: updates only on a read access
  always_ff @(posedge clk) begin
    if (rst)     bus.q <= '0;
    else if (rd) bus.q <= rd_data;
  end

endmodule

// File: tb/tb_keypad_mmio.sv
// Directed bench for keypad_mmio with a read scoreboard. Log-order steps
// are built only when KEYPAD_ORDER_LOG_EN is defined.
`timescale 1ns/1ps
module tb_keypad_mmio;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NK = 4;
  localparam int DB = 8;

  typedef struct {
    string        tag;
    logic [DW-1:0] exp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] keys_in = '0;
  logic [NK-1:0] leds;
  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;

  keypad_mmio_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  keypad_mmio #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_KEYS(NK), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .keys_in (keys_in),
    .leds    (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.en = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data = d;
    @(posedge clk); #1;
    bus.en = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input string tag);
    exp_t x;
    @(negedge clk);
    bus.en = 1'b1; bus.we = 1'b0; bus.addr = a;
    x.tag = tag; x.exp = e;
    sb.push_back(x);
    @(posedge clk); #1;
    bus.en = 1'b0;
    x = sb.pop_front();
    check(x.tag, 32'(bus.q), 32'(x.exp));
  endtask

  task automatic set_keys(input logic [NK-1:0] v, input int hold);
    @(negedge clk);
    keys_in = v;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.en = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data = '0; bus.glyph_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", 32'(bus.q), 0);
    check("rst_leds", 32'(leds), 0);
    check("rst_valid", 32'(bus.glyph_valid), 0);
    check("rst_gkey", 32'(bus.glyph_key), 0);
    check("rst_gdata", 32'(bus.glyph_data), 0);
    @(negedge clk) rst = 1'b0;
    bus_read(16'h0300, 16'h0000, "glb_after_rst");

    // LEDs and unmapped key
    bus_write(16'h0002, 16'h0001);
    check("led_write", 32'(leds), 32'h4);
    bus_read(16'h0002, 16'h0001, "led_rd2");
    bus_read(16'h0001, 16'h0000, "led_rd1");
    bus_write(16'h0007, 16'h0001);
    check("led_unmapped", 32'(leds), 32'h4);
    bus_read(16'h0007, 16'h0000, "led_rd7");

    // Debounce: a short glitch is filtered, a long hold is accepted
    set_keys(4'b0010, 5);
    set_keys(4'b0000, DB + 4);
    bus_read(16'h0201, 16'h0000, "glitch_status");
    set_keys(4'b0010, DB + 4);
    bus_read(16'h0201, 16'h0003, "press_status");
    bus_read(16'h0300, 16'h0100, "press_count");
    bus_write(16'h0201, 16'h0002);
    bus_read(16'h0201, 16'h0001, "flag_cleared");
    bus_read(16'h0300, 16'h0000, "count_cleared");

    // Glyph handshake with a stalled driver
    bus_write(16'h0103, 16'h002A);
    check("glyph_valid", 32'(bus.glyph_valid), 1);
    check("glyph_key", 32'(bus.glyph_key), 3);
    check("glyph_data", 32'(bus.glyph_data), 32'h2A);
    bus_read(16'h0300, 16'h0001, "glb_busy");
    bus_write(16'h0103, 16'h0055);
    check("glyph_data_hold", 32'(bus.glyph_data), 32'h2A);
    bus_read(16'h0300, 16'h0003, "glb_ovr");
    bus_read(16'h0103, 16'h0000, "glyph_rd");
    @(negedge clk) bus.glyph_ready = 1'b1;
    check("valid_in_xfer", 32'(bus.glyph_valid), 1);
    @(posedge clk); #1;
    check("valid_dropped", 32'(bus.glyph_valid), 0);
    bus.glyph_ready = 1'b0;
    bus_write(16'h0300, 16'h0002);
    bus_read(16'h0300, 16'h0000, "ovr_cleared");

    // Glyph write landing in the transfer cycle is dropped
    bus_write(16'h0102, 16'h0077);
    bus.glyph_ready = 1'b1;
    bus_write(16'h0101, 16'h0099);
    bus.glyph_ready = 1'b0;
    check("xfer_wr_valid", 32'(bus.glyph_valid), 0);
    check("xfer_wr_key", 32'(bus.glyph_key), 2);
    check("xfer_wr_data", 32'(bus.glyph_data), 32'h77);
    bus_read(16'h0300, 16'h0002, "xfer_wr_ovr");
    bus_write(16'h0300, 16'h0002);

    // Clear arriving on the exact cycle the press sets the flag (2 + DB + 1 edges)
    @(negedge clk) keys_in[0] = 1'b1;
    repeat (DB + 2) @(posedge clk);
    bus_write(16'h0200, 16'h0002);
    bus_read(16'h0200, 16'h0003, "press_beats_clear");
    bus_read(16'h0300, 16'h0100, "press_beats_count");

    // Reset in the middle of a pending glyph
    bus_write(16'h0101, 16'h0011);
    check("pend_valid", 32'(bus.glyph_valid), 1);
    set_keys(4'b0000, DB + 4);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", 32'(bus.glyph_valid), 0);
    check("abort_leds", 32'(leds), 0);
    @(negedge clk) rst = 1'b0;
    bus.glyph_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.glyph_ready = 1'b0;
    check("abort_stays", 32'(bus.glyph_valid), 0);
    bus_read(16'h0300, 16'h0000, "abort_glb");

`ifdef KEYPAD_ORDER_LOG_EN
    // Press order 2, 0, 3 is replayed by the log
    set_keys(4'b0100, DB + 4);
    set_keys(4'b0101, DB + 4);
    set_keys(4'b1101, DB + 4);
    bus_read(16'h0400, 16'h8002, "log_pop0");
    bus_read(16'h0400, 16'h8000, "log_pop1");
    bus_read(16'h0400, 16'h8003, "log_pop2");
    bus_read(16'h0400, 16'h0000, "log_empty");
    set_keys(4'b0000, DB + 4);
    // Simultaneous presses: lowest index kept, overflow flagged
    set_keys(4'b0011, DB + 4);
    bus_read(16'h0400, 16'h8000, "sim_pop");
    bus_read(16'h0400, 16'h0000, "sim_empty");
    bus_read(16'h0300, 16'h0404, "sim_lovf");
    bus_write(16'h0300, 16'h0004);
    bus_read(16'h0300, 16'h0400, "lovf_cleared");
`else
    // Without the log, func 4 and lovf read 0
    set_keys(4'b0011, DB + 4);
    bus_read(16'h0400, 16'h0000, "nolog_rd");
    bus_read(16'h0300, 16'h0200, "nolog_glb");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
